// File: rtl/serial_add_pkg.sv
// serial_add_pkg: FSM states and counter sizing shared by the serial adder.
package serial_add_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// full_adder_bit: combinational 1-bit full adder from two half adders and an OR.
module full_adder_bit (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s1, c1, c2;

    assign s1 = x ^ y;
    assign c1 = x & y;
    assign s  = s1 ^ ci;
    assign c2 = s1 & ci;
    assign co = c1 | c2;

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial LSB-first adder; SERIAL_ADD_SUB_EN adds a subtract mode.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nxt;
    logic [CW-1:0] cnt;
    logic carry, s, co, load;

    full_adder_bit u_fa (
        .x (a_sh[0]),
        .y (b_sh[0]),
        .ci(carry),
        .s (s),
        .co(co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state == IDLE ? (start ? RUN : IDLE) :
                    state == RUN  ? (cnt == LAST ? DONE : RUN) : IDLE;
    end

    always_comb begin
        busy = state == RUN;
        done = state == DONE;
    end

    assign load    = state == IDLE && start;
    // new sum bit enters at the MSB so the LSB-first stream lands in place
    assign sum_nxt = WIDTH'({s, sum_sh} >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else if (load) begin
            a_sh   <= a;
`ifdef SERIAL_ADD_SUB_EN
            b_sh   <= sub ? ~b : b;
            carry  <= sub;
`else
            b_sh   <= b;
            carry  <= 1'b0;
`endif
            sum_sh <= '0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= sum_nxt;
            carry  <= co;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) begin
                sum  <= sum_nxt;
                cout <= co;
            end
        end
    end

endmodule
